// File: rtl/regfile_wb_arbiter.sv
// Two-port round-robin writeback arbiter feeding a single register-file write port.
// Optional bypass outputs are built when WB_ARB_FWD_EN is defined.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     p0_valid,
  input  logic [ADDRESS_WIDTH-1:0] p0_dest,
  input  logic [DATA_WIDTH-1:0]    p0_data,
  output logic                     p0_ready,
  input  logic                     p1_valid,
  input  logic [ADDRESS_WIDTH-1:0] p1_dest,
  input  logic [DATA_WIDTH-1:0]    p1_data,
  output logic                     p1_ready,
`ifdef WB_ARB_FWD_EN
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DATA_WIDTH-1:0]    fwd1_data,
  output logic [DATA_WIDTH-1:0]    fwd2_data,
`endif
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic [15:0]              collisions
);

  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = {ADDRESS_WIDTH{1'b0}};

  logic                     grant0_s, grant1_s;
  logic                     last_grant_q, last_grant_d;
  logic                     reg_write_q, reg_write_d;
  logic [ADDRESS_WIDTH-1:0] wrt_dest_q, wrt_dest_d;
  logic [DATA_WIDTH-1:0]    wrt_data_q, wrt_data_d;
  logic [15:0]              collisions_q, collisions_d;

  // Grant selection; last_grant_q = 1 means port 1 was served last, so port 0 wins a tie.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst && !flush) begin
      if (p0_valid && (!p1_valid || last_grant_q)) begin
        grant0_s = 1'b1;
      end else if (p1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
    end
  end

  // Next-state for round-robin pointer, write port and collision counter.
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    wrt_dest_d   = wrt_dest_q;
    wrt_data_d   = wrt_data_q;
    collisions_d = collisions_q;
    if (grant0_s) begin
      last_grant_d = 1'b0;
      if (p0_dest != ZERO_ADDR) begin
        reg_write_d = 1'b1;
        wrt_dest_d  = p0_dest;
        wrt_data_d  = p0_data;
      end else begin
        reg_write_d = 1'b0;
      end
    end else if (grant1_s) begin
      last_grant_d = 1'b1;
      if (p1_dest != ZERO_ADDR) begin
        reg_write_d = 1'b1;
        wrt_dest_d  = p1_dest;
        wrt_data_d  = p1_data;
      end else begin
        reg_write_d = 1'b0;
      end
    end else begin
      reg_write_d = 1'b0;
    end
    if (p0_valid && p1_valid && !flush && (collisions_q != 16'hFFFF)) begin
      collisions_d = collisions_q + 16'd1;
    end else begin
      collisions_d = collisions_q;
    end
  end

  // State registers; reset drops any pending write and re-arms port 0 priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      wrt_dest_q   <= ZERO_ADDR;
      wrt_data_q   <= {DATA_WIDTH{1'b0}};
      collisions_q <= 16'd0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      wrt_dest_q   <= wrt_dest_d;
      wrt_data_q   <= wrt_data_d;
      collisions_q <= collisions_d;
    end
  end

  assign p0_ready    = grant0_s;
  assign p1_ready    = grant1_s;
  assign RegWrite    = reg_write_q;
  assign rg_wrt_dest = wrt_dest_q;
  assign rg_wrt_data = wrt_data_q;
  assign collisions  = collisions_q;

`ifdef WB_ARB_FWD_EN
  // Bypass of the in-flight register-file write; x0 never forwards.
  assign fwd1_hit  = reg_write_q && (wrt_dest_q == rs1) && (rs1 != ZERO_ADDR);
  assign fwd2_hit  = reg_write_q && (wrt_dest_q == rs2) && (rs2 != ZERO_ADDR);
  assign fwd1_data = fwd1_hit ? wrt_data_q : {DATA_WIDTH{1'b0}};
  assign fwd2_data = fwd2_hit ? wrt_data_q : {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_WIDTH, 32, bits per register word.
  ADDRESS_WIDTH, 5, register address width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state updates on posedge.
  rst  in  1  reset, asynchronous and active-low.
  flush  in  1  synchronous flush; blocks grants.
  p0_valid  in  1  requester 0 (ALU writeback) has a write.
  p0_dest  in  ADDRESS_WIDTH  requester 0 destination register.
  p0_data  in  DATA_WIDTH  requester 0 write data.
  p0_ready  out  1  requester 0 write accepted this cycle.
  p1_valid  in  1  requester 1 (load writeback) has a write.
  p1_dest  in  ADDRESS_WIDTH  requester 1 destination register.
  p1_data  in  DATA_WIDTH  requester 1 write data.
  p1_ready  out  1  requester 1 write accepted this cycle.
  RegWrite  out  1  register-file write enable, registered.
  rg_wrt_dest  out  ADDRESS_WIDTH  register-file write address, registered.
  rg_wrt_data  out  DATA_WIDTH  register-file write data, registered.
  collisions  out  16  saturating count of cycles where both requesters were valid.

Function
REQ-003 A transfer on port n SHALL occur in a cycle where pn_valid=1 and pn_ready=1.
REQ-004 pn_ready SHALL be combinational and SHALL be 1 only for the single granted port.
REQ-005 At most one of p0_ready and p1_ready SHALL be 1 in any cycle.
REQ-006 With flush=0 and exactly one valid port, that port SHALL be granted.
REQ-007 With flush=0 and both ports valid, the grant SHALL go to the port not recorded in last_grant (round-robin).
REQ-008 last_grant SHALL update to the granted port on every grant.
REQ-009 last_grant SHALL be unchanged in cycles with no grant.
REQ-010 A requester not granted SHALL hold valid, dest and data stable until it is granted; the arbiter SHALL NOT drop a held request.
REQ-011 One cycle after a grant, RegWrite SHALL be 1, with rg_wrt_dest/rg_wrt_data equal to the granted port's dest/data (latency 1).
REQ-012 A granted transfer with dest=0 SHALL be accepted (ready=1), but the next cycle SHALL show RegWrite=0 and rg_wrt_dest/rg_wrt_data unchanged.
REQ-013 In cycles with no grant, the next-cycle RegWrite SHALL be 0 and rg_wrt_dest/rg_wrt_data SHALL hold their previous values.
REQ-014 With flush=1, both ready outputs SHALL be 0, the next-cycle RegWrite SHALL be 0, and last_grant SHALL be unchanged.
REQ-015 collisions SHALL increment by 1 in each cycle where p0_valid=p1_valid=1 and flush=0.
REQ-016 collisions SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-017 Fairness: under continuous contention, each port SHALL be granted at least once every 2 cycles.

Reset
REQ-018 Asserting rst=0 SHALL immediately clear all outputs and state, independent of clk: RegWrite=0, rg_wrt_dest=0, rg_wrt_data=0, collisions=0, last_grant=1.
REQ-019 With last_grant=1 after reset, the first collision SHALL go to port 0.
REQ-020 Reset asserted mid-operation SHALL discard any pending output write.
REQ-021 A transfer granted in the cycle rst asserts SHALL NOT reach the register file.
REQ-022 Ready outputs SHALL be 0 while rst=0.

Configuration
REQ-023 Macro WB_ARB_FWD_EN SHALL add inputs rs1 and rs2 (ADDRESS_WIDTH each) and outputs fwd1_hit, fwd2_hit (1 bit each) and fwd1_data, fwd2_data (DATA_WIDTH each).
REQ-024 With WB_ARB_FWD_EN defined, fwdN_hit SHALL be combinational and SHALL be 1 iff RegWrite=1, rg_wrt_dest=rsN and rsN!=0.
REQ-025 With WB_ARB_FWD_EN defined, fwdN_data SHALL equal rg_wrt_data when fwdN_hit=1, else 0.
REQ-026 Without WB_ARB_FWD_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 After reset, p0_valid=1, dest=3, data=32'hA5A5A5A5 for one cycle -> p0_ready=1; next cycle RegWrite=1, rg_wrt_dest=3, rg_wrt_data=32'hA5A5A5A5.
REQ-028 Both ports valid for 4 cycles (dest 1/2) -> grants alternate P0,P1,P0,P1; collisions=4.
REQ-029 p1_valid=1, dest=0, data=32'hFFFFFFFF -> p1_ready=1; next cycle RegWrite=0.
REQ-030 Both valid with flush=1 for 2 cycles -> no ready; RegWrite=0; collisions unchanged; first grant after flush goes to port 0.
REQ-031 Grant issued, then rst=0 asynchronously before the next edge -> RegWrite=0 at once; no write appears after release.
REQ-032 With WB_ARB_FWD_EN, write to reg 7 with rs1=7, rs2=0 -> fwd1_hit=1, fwd1_data=write data, fwd2_hit=0 during the RegWrite cycle.
